// File: rtl/pool_window_gen.sv
// pool_window_gen: streaming 2x2 stride-2 window generator feeding a max-pooling stage
// Ports: clk, rst (async, active high); in_valid/in_sof/in_data raster pixel stream with in_ready;
// win_valid plus win_tl/win_tr/win_bl/win_br window output; frame_done with the frame's last window.
// Define POOL_CEIL_EN for ceil mode (odd edges zero-padded); the default build is floor mode.
module pool_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              win_valid,
  output logic [DATA_W-1:0] win_tl,
  output logic [DATA_W-1:0] win_tr,
  output logic [DATA_W-1:0] win_bl,
  output logic [DATA_W-1:0] win_br,
  output logic              frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
`ifdef POOL_CEIL_EN
  localparam bit CEIL = 1'b1;
`else
  localparam bit CEIL = 1'b0;
`endif
  localparam bit PAD_C = CEIL && (IMG_W % 2 == 1);
  localparam bit PAD_R = CEIL && (IMG_H % 2 == 1);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  // position of the bottom-right pixel of the frame's final window
  localparam logic [CW-1:0] C_FIN = PAD_C ? C_LAST : CW'(IMG_W / 2 * 2 - 1);
  localparam logic [RW-1:0] R_FIN = PAD_R ? R_LAST : RW'(IMG_H / 2 * 2 - 1);
  logic [DATA_W-1:0] line_q [IMG_W];
  logic [DATA_W-1:0] left_q, tl_q, tr_q, bl_q, br_q, tl_d, tr_d, bl_d, br_d;
  logic [CW-1:0] col_q, col_d, c, c_ev;
  logic [RW-1:0] row_q, row_d, r;
  logic win_valid_q, frame_done_q, acc, pad_row, pad_col, emit, last;
  assign in_ready   = !rst;
  assign acc        = in_valid && !rst;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign win_tl     = tl_q;
  assign win_tr     = tr_q;
  assign win_bl     = bl_q;
  assign win_br     = br_q;
  always_comb begin
    c       = in_sof ? '0 : col_q;
    r       = in_sof ? '0 : row_q;
    c_ev    = c & ~CW'(1);
    pad_row = PAD_R && r == R_LAST;
    pad_col = PAD_C && c == C_LAST;
    emit    = acc && (r[0] || pad_row) && (c[0] || pad_col);
    last    = r == R_FIN && c == C_FIN;
    col_d   = c == C_LAST ? '0 : c + CW'(1);
    row_d   = c != C_LAST ? r : r == R_LAST ? '0 : r + RW'(1);
    // on a padded odd-width column c is even, so c_ev addresses buf[col] there
    tl_d    = pad_row ? (c[0] ? left_q : in_data) : line_q[c_ev];
    tr_d    = !c[0] ? '0 : pad_row ? in_data : line_q[c];
    bl_d    = pad_row ? '0 : c[0] ? left_q : in_data;
    br_d    = (pad_row || !c[0]) ? '0 : in_data;
  end
  always_ff @(posedge clk)
    if (acc && !r[0] && !pad_row) line_q[c] <= in_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      left_q       <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      tl_q         <= '0;
      tr_q         <= '0;
      bl_q         <= '0;
      br_q         <= '0;
    end else begin
      if (acc) begin
        col_q <= col_d;
        row_q <= row_d;
      end
      if (acc && !c[0] && (r[0] || pad_row)) left_q <= in_data;
      win_valid_q  <= emit;
      frame_done_q <= emit && last;
      if (emit) begin
        tl_q <= tl_d;
        tr_q <= tr_d;
        bl_q <= bl_d;
        br_q <= br_d;
      end
    end
endmodule

// File: tb/tb_pool_window_gen.sv
// tb_pool_window_gen: scoreboard bench driving one stream into 4x4 and 3x3 pool_window_gen instances
module tb_pool_window_gen;
`ifdef POOL_CEIL_EN
  localparam bit CEIL = 1'b1;
`else
  localparam bit CEIL = 1'b0;
`endif
  typedef struct {
    logic [31:0] px;
    logic        fd;
    int          cyc;
  } win_t;
  logic clk = 0, rst = 1, in_valid = 0, in_sof = 0;
  logic [7:0] in_data = 0;
  logic rdy4, v4, fd4, rdy3, v3, fd3;
  logic [7:0] tl4, tr4, bl4, br4, tl3, tr3, bl3, br3;
  int total = 0, bad = 0, cyc = 0;
  win_t q4[$], q3[$];
  win_t e4 = '{32'd0, 1'b0, 0};
  win_t e3 = '{32'd0, 1'b0, 0};
  logic [7:0] img [2][4][4];
  int mr[2] = '{0, 0};
  int mc[2] = '{0, 0};

  pool_window_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .in_ready(rdy4), .win_valid(v4), .win_tl(tl4), .win_tr(tr4), .win_bl(bl4), .win_br(br4),
    .frame_done(fd4));
  pool_window_gen #(.DATA_W(8), .IMG_W(3), .IMG_H(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .in_ready(rdy3), .win_valid(v3), .win_tl(tl3), .win_tr(tr3), .win_bl(bl3), .win_br(br3),
    .frame_done(fd3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  function automatic logic [7:0] pix(input int id, input int r, input int c, input int n);
    return (r < n && c < n) ? img[id][r][c] : 8'd0;
  endfunction

  function automatic int lim(input int v, input int n);
    return v < n ? v : n - 1;
  endfunction

  // Frame model: block (bi,bj) covers rows 2bi..2bi+1, cols 2bj..2bj+1; it is complete when its
  // last in-image pixel arrives; out-of-image pixels read as zero; blocks past the edge exist only in ceil mode.
  task automatic model(input int id, input bit sof, input logic [7:0] d);
    int n, nb, r, c, bi, bj;
    win_t e;
    n  = id ? 3 : 4;
    nb = CEIL ? (n + 1) / 2 : n / 2;
    if (sof) begin
      mr[id] = 0;
      mc[id] = 0;
    end
    r  = mr[id];
    c  = mc[id];
    img[id][r][c] = d;
    bi = r / 2;
    bj = c / 2;
    if (bi < nb && bj < nb && r == lim(2 * bi + 1, n) && c == lim(2 * bj + 1, n)) begin
      e.px  = {pix(id, 2 * bi, 2 * bj, n), pix(id, 2 * bi, 2 * bj + 1, n),
               pix(id, 2 * bi + 1, 2 * bj, n), pix(id, 2 * bi + 1, 2 * bj + 1, n)};
      e.fd  = bi == nb - 1 && bj == nb - 1;
      e.cyc = cyc + 1;
      if (id == 0) q4.push_back(e);
      else q3.push_back(e);
    end
    mc[id] = (c + 1) % n;
    if (c == n - 1) mr[id] = (r + 1) % n;
  endtask

  task automatic send(input logic [7:0] d, input bit sof, input int gap);
    in_valid = 1;
    in_sof   = sof;
    in_data  = d;
    model(0, sof, d);
    model(1, sof, d);
    @(posedge clk); #1;
    in_valid = 0;
    in_sof   = 0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q4.delete();
      q3.delete();
      e4 = '{32'd0, 1'b0, 0};
      e3 = '{32'd0, 1'b0, 0};
    end
    if (v4) begin
      chk("w4_expected", q4.size() != 0, 1);
      if (q4.size() != 0) e4 = q4.pop_front();
      chk("w4_cycle", cyc, e4.cyc);
    end
    chk("w4_window", {tl4, tr4, bl4, br4}, e4.px);
    chk("w4_frame_done", fd4, v4 && e4.fd);
    if (v3) begin
      chk("w3_expected", q3.size() != 0, 1);
      if (q3.size() != 0) e3 = q3.pop_front();
      chk("w3_cycle", cyc, e3.cyc);
    end
    chk("w3_window", {tl3, tr3, bl3, br3}, e3.px);
    chk("w3_frame_done", fd3, v3 && e3.fd);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid4", v4, 0);
    chk("reset_win4", {tl4, tr4, bl4, br4}, 0);
    chk("reset_fd4", fd4, 0);
    chk("reset_ready4", rdy4, 0);
    chk("reset_ready3", rdy3, 0);
    rst = 0;
    #1;
    chk("ready_after_reset", {rdy4, rdy3}, 2'b11);
    for (int i = 0; i < 16; i++) send(8'(i), i == 0, 0);
    for (int i = 0; i < 16; i++) send(8'(i), i == 0, int'($urandom_range(0, 3)));
    for (int i = 0; i < 7; i++) send(8'(i), i == 0, 0);
    for (int i = 0; i < 16; i++) send(8'(100 + i), i == 0, 0);
    for (int i = 0; i < 10; i++) send(8'(i), i == 0, 0);
    rst = 1;
    #1;
    chk("async_rst_win4", {tl4, tr4, bl4, br4}, 0);
    chk("async_rst_win3", {tl3, tr3, bl3, br3}, 0);
    chk("async_rst_valid", {v4, v3, fd4, fd3}, 0);
    chk("async_rst_ready", {rdy4, rdy3}, 0);
    mr = '{0, 0};
    mc = '{0, 0};
    @(posedge clk); #1;
    chk("rst_held_ready", {rdy4, rdy3}, 0);
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 0);
    for (int i = 0; i < 9; i++) send(8'(i), i == 0, 0);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 16; i++) send(8'($urandom), i == 0, 0);
    for (int i = 0; i < 300; i++)
      send(8'($urandom), $urandom_range(0, 39) == 0, int'($urandom_range(0, 2)));
    repeat (4) @(posedge clk);
    #1;
    chk("q4_drained", q4.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
